// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) FSMs
// over a DEPTH-word memory. Full-width beats only. Transfer size is ignored,
// and WRAP bursts step their word index like INCR.
// Optional build macro AXI_RESP_ERR_EN: when defined, out-of-range word
// indices give SLVERR and do not alias. When undefined, the word index wraps
// modulo DEPTH and every response is OKAY.
module axi_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int DEPTH      = 256
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [ID_WIDTH-1:0]   s_awid_i,
  input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic [7:0]            s_awlen_i,
  input  logic [2:0]            s_awsize_i,
  input  logic [1:0]            s_awburst_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic                  s_wlast_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [ID_WIDTH-1:0]   s_bid_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [7:0]            s_arlen_i,
  input  logic [2:0]            s_arsize_i,
  input  logic [1:0]            s_arburst_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rlast_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
`ifdef AXI_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [8:0]            w_count;
  logic [1:0]            w_burst;
  logic [ID_WIDTH-1:0]   w_id;
  logic                  w_err;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [8:0]            r_count;
  logic [1:0]            r_burst;

  logic [ADDR_WIDTH-1:0] aw_index;
  logic [ADDR_WIDTH-1:0] ar_index;
  logic [ADDR_WIDTH-1:0] r_next;
  logic                  unused_inputs;

  // Word index for the next beat: FIXED holds, INCR/WRAP step by one word.
  function automatic logic [ADDR_WIDTH-1:0] next_index(input logic [ADDR_WIDTH-1:0] idx,
                                                       input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + ADDR_WIDTH'(1);
  endfunction

  // Out-of-range indices only matter when error responses are enabled.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return !ERR_EN || (idx < DEPTH_A);
  endfunction

  // Physical row; in the error build in-range indices are already < DEPTH.
  function automatic logic [IW-1:0] mem_index(input logic [ADDR_WIDTH-1:0] idx);
    return IW'(idx % DEPTH_A);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] idx);
    return in_range(idx) ? mem[mem_index(idx)] : {DATA_WIDTH{1'b0}};
  endfunction

  assign aw_index      = s_awaddr_i >> BYTE_SHIFT;
  assign ar_index      = s_araddr_i >> BYTE_SHIFT;
  assign r_next        = next_index(r_idx, r_burst);
  assign unused_inputs = ^{s_awsize_i, s_arsize_i, s_wlast_i};

  // Write channel FSM: accept AW, count beats by awlen (not wlast), then hold B.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      w_state     <= W_IDLE;
      s_awready_o <= 1'b1;
      s_wready_o  <= 1'b0;
      s_bvalid_o  <= 1'b0;
      s_bid_o     <= {ID_WIDTH{1'b0}};
      s_bresp_o   <= RESP_OKAY;
      w_idx       <= {ADDR_WIDTH{1'b0}};
      w_count     <= 9'd0;
      w_burst     <= 2'b00;
      w_id        <= {ID_WIDTH{1'b0}};
      w_err       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_awvalid_i) begin
            w_idx       <= aw_index;
            w_count     <= {1'b0, s_awlen_i} + 9'd1;
            w_burst     <= s_awburst_i;
            w_id        <= s_awid_i;
            w_err       <= 1'b0;
            s_awready_o <= 1'b0;
            s_wready_o  <= 1'b1;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_wvalid_i) begin
            w_idx <= next_index(w_idx, w_burst);
            if (!in_range(w_idx)) begin
              w_err <= 1'b1;
            end
            if (w_count == 9'd1) begin
              s_wready_o <= 1'b0;
              s_bvalid_o <= 1'b1;
              s_bid_o    <= w_id;
              s_bresp_o  <= (w_err || !in_range(w_idx)) ? RESP_SLVERR : RESP_OKAY;
              w_state    <= W_RESP;
            end else begin
              w_count <= w_count - 9'd1;
            end
          end
        end
        W_RESP: begin
          if (s_bready_i) begin
            s_bvalid_o  <= 1'b0;
            s_awready_o <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: begin
          s_awready_o <= 1'b1;
          s_wready_o  <= 1'b0;
          s_bvalid_o  <= 1'b0;
          w_state     <= W_IDLE;
        end
      endcase
    end
  end

  // Memory array: written on each accepted W beat; contents survive reset.
  always_ff @(posedge aclk) begin
    if ((w_state == W_DATA) && s_wvalid_i && in_range(w_idx)) begin
      mem[mem_index(w_idx)] <= s_wdata_i;
    end
  end

  // Read channel FSM: register each beat from memory, advance on R handshake.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state     <= R_IDLE;
      s_arready_o <= 1'b1;
      s_rvalid_o  <= 1'b0;
      s_rlast_o   <= 1'b0;
      s_rid_o     <= {ID_WIDTH{1'b0}};
      s_rdata_o   <= {DATA_WIDTH{1'b0}};
      s_rresp_o   <= RESP_OKAY;
      r_idx       <= {ADDR_WIDTH{1'b0}};
      r_count     <= 9'd0;
      r_burst     <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid_i) begin
            r_idx       <= ar_index;
            r_count     <= {1'b0, s_arlen_i} + 9'd1;
            r_burst     <= s_arburst_i;
            s_rid_o     <= s_arid_i;
            s_rdata_o   <= read_word(ar_index);
            s_rresp_o   <= in_range(ar_index) ? RESP_OKAY : RESP_SLVERR;
            s_rlast_o   <= (s_arlen_i == 8'd0);
            s_rvalid_o  <= 1'b1;
            s_arready_o <= 1'b0;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready_i) begin
            if (s_rlast_o) begin
              s_rvalid_o  <= 1'b0;
              s_rlast_o   <= 1'b0;
              s_arready_o <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_idx     <= r_next;
              r_count   <= r_count - 9'd1;
              s_rdata_o <= read_word(r_next);
              s_rresp_o <= in_range(r_next) ? RESP_OKAY : RESP_SLVERR;
              s_rlast_o <= (r_count == 9'd2);
            end
          end
        end
        default: begin
          s_arready_o <= 1'b1;
          s_rvalid_o  <= 1'b0;
          s_rlast_o   <= 1'b0;
          r_state     <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits; only full-width beats are supported.
REQ-003 SHALL have parameter ID_WIDTH, default 3, AWID/ARID/BID/RID width.
REQ-004 SHALL have parameter DEPTH, default 256, memory size in DATA_WIDTH words.
REQ-005 SHALL have ports as follows:
- aclk  in  1  sole clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- s_awid_i / s_awaddr_i / s_awlen_i[8] / s_awsize_i[3] / s_awburst_i[2] / s_awvalid_i  in  write address; s_awready_o  out  1.
- s_wdata_i[DATA_WIDTH] / s_wlast_i / s_wvalid_i  in  write data; s_wready_o  out  1.
- s_bid_o[ID_WIDTH] / s_bresp_o[2] / s_bvalid_o  out  write response; s_bready_i  in  1.
- s_arid_i / s_araddr_i / s_arlen_i[8] / s_arsize_i[3] / s_arburst_i[2] / s_arvalid_i  in  read address; s_arready_o  out  1.
- s_rid_o / s_rdata_o[DATA_WIDTH] / s_rresp_o[2] / s_rlast_o / s_rvalid_o  out  read data; s_rready_i  in  1.

Function
REQ-006 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); only one asserted ready/valid per state.
REQ-007 On AW handshake, SHALL latch id, word index = awaddr >> log2(DATA_WIDTH/8), beat count = awlen+1, burst type; go to W_DATA.
REQ-008 In W_DATA, each W handshake SHALL write wdata to the current word; the index increments by 1 for INCR (01) and WRAP (10) and holds for FIXED (00).
REQ-009 The write burst SHALL end on the awlen+1-th beat regardless of s_wlast_i; the FSM then goes to W_RESP with bid = latched id.
REQ-010 In W_RESP, bvalid SHALL hold until bready is sampled high, then the FSM returns to W_IDLE; awready SHALL be low until then.
REQ-011 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (rvalid=1); it is independent of the write FSM.
REQ-012 On AR handshake, SHALL latch id, index, count and burst; rdata SHALL be registered from memory on the same edge, so rvalid rises 1 cycle after the handshake.
REQ-013 On each R handshake that is not the last beat, SHALL advance the index per REQ-008 and register the next word; rvalid stays high (one beat per cycle when rready=1).
REQ-014 rlast SHALL be high exactly on the arlen+1-th beat; its handshake returns the FSM to R_IDLE.
REQ-015 rdata/rid/rresp/rlast and bid/bresp SHALL stay stable while valid is high and ready is low.
REQ-016 s_awsize_i/s_arsize_i SHALL be ignored; the index SHALL be computed at ADDR_WIDTH width with no overflow trap.
REQ-017 A write and a read registration of the same word on the same edge: the read SHALL return the old data.

Reset
REQ-018 While arst=1: both FSMs SHALL be in IDLE; awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bid, rid, bresp, rresp, rdata=0.
REQ-019 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL NOT be cleared.

Configuration
REQ-020 Macro AXI_RESP_ERR_EN defined: a word index >= DEPTH SHALL suppress that beat's write, return rdata=0 with rresp=2'b10 on that beat, and return bresp=2'b10 if any beat of the burst was out of range.
REQ-021 Macro AXI_RESP_ERR_EN undefined: the index SHALL be taken modulo DEPTH, and bresp/rresp SHALL always be 2'b00.

Verification
REQ-022 AW id=3 addr=0x8 len=3; W 0xA,0xB,0xC,0xD with wlast on beat 4 -> mem[2..5]=A..D; bvalid with bid=3, bresp=00; one response only.
REQ-023 AR id=5 addr=0x8 len=3, rready=1 -> rvalid 1 cycle after AR; rdata A,B,C,D on consecutive cycles; rlast on D only; rid=5.
REQ-024 R beats with rready toggled 1,0,0,1 -> rdata held stable during stall; no beat lost or duplicated.
REQ-025 FIXED write addr=0x10 len=2 data 1,2,3, then read -> mem[4]=3; a FIXED read len=1 returns 3,3.
REQ-026 AXI_RESP_ERR_EN, write addr=(DEPTH-1)*4 len=1 -> mem[DEPTH-1] written, beat 2 dropped, bresp=10; without the macro, beat 2 is written to mem[0] and bresp=00.
REQ-027 arst pulsed during W_DATA beat 2 -> awready=1, wready=0, bvalid=0 after reset; a new burst then completes normally.
